// File: rtl/fifo_read_ctrl.sv
// Read-side controller of a dual-clock FIFO: write-pointer synchroniser, empty/fill tracking,
// RAM read issue and a two-entry first-word-fall-through output buffer.
module fifo_read_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_r,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  en_r,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
    logic [PtrW-1:0] b;
    b[PtrW-1] = g[PtrW-1];
    for (int i = int'(PtrW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PtrW-1:0] bin2gray(input logic [PtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PtrW-1:0]       sync1_q, sync2_q;
  logic [PtrW-1:0]       wr_ptr_sync_bin;
  logic [PtrW-1:0]       rd_ptr_bin_q, rd_ptr_bin_d;
  logic [PtrW-1:0]       rd_ptr_gray_q, rd_ptr_gray_d;
  logic                  pending_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  pop;
  logic [2:0]            committed;

  assign wr_ptr_sync_bin = gray2bin(sync2_q);
  assign empty           = (rd_ptr_bin_q == wr_ptr_sync_bin);
  assign pop_valid       = (occ_q != 2'd0);
  assign pop_data        = head_q;
  assign pop             = pop_valid && pop_ready;
  assign read_addr       = rd_ptr_bin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray     = rd_ptr_gray_q;

  // Words already owned by the buffer once this cycle's pop retires; issue only if one slot is free.
  assign committed = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};
  assign en_r      = !empty && (committed < 3'd2);

  assign fill_level = (wr_ptr_sync_bin - rd_ptr_bin_q)
                    + {{(PtrW-1){1'b0}}, pending_q}
                    + {{(PtrW-2){1'b0}}, occ_q};

  always_comb begin
    rd_ptr_bin_d  = rd_ptr_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    if (en_r) begin
      rd_ptr_bin_d  = rd_ptr_bin_q + 1'b1;
      rd_ptr_gray_d = bin2gray(rd_ptr_bin_q + 1'b1);
    end
  end

  // Pop first, then land the returning RAM word in the first free slot.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (pop) begin
      head_d = skid_q;
      occ_d  = occ_q - 2'd1;
    end
    if (pending_q) begin
      if (occ_d == 2'd0) begin
        head_d = ram_out;
      end else begin
        skid_d = ram_out;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk_r or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      pending_q     <= 1'b0;
      occ_q         <= 2'd0;
      head_q        <= '0;
      skid_q        <= '0;
    end else begin
      sync1_q       <= wr_ptr_gray;
      sync2_q       <= sync1_q;
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      pending_q     <= en_r;
      occ_q         <= occ_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural 1-cycle-latency RAM.
module tb_fifo_read_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk_r = 1'b0;
  logic          reset;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic          en_r;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] ram_out;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          pop_ready;
  logic          empty;
  logic [AW:0]   fill_level;

  logic [DW-1:0] mem [16];
  int            checks = 0;
  int            errors = 0;

  always #5 clk_r = ~clk_r;

  fifo_read_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_r      (clk_r),
    .reset      (reset),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .en_r       (en_r),
    .read_addr  (read_addr),
    .ram_out    (ram_out),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .empty      (empty),
    .fill_level (fill_level)
  );

  always @(posedge clk_r) begin
    if (en_r) ram_out <= mem[read_addr];
  end

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [DW-1:0] word(input int a);
    return 8'hA0 + 8'(a % 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_r);
    #1;
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    ram_out     = '0;
    reset       = 1'b1;
    wr_ptr_gray = '0;
    pop_ready   = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_pop_valid", pop_valid, 0);
    check("rst_en_r", en_r, 0);
    check("rst_empty", empty, 1);
    check("rst_fill", fill_level, 0);
    check("rst_rd_gray", rd_ptr_gray, 0);
    step();
    step();
    reset = 1'b1;
    step();

    // Single burst of three words
    wr_ptr_gray = gray(3);
    pop_ready   = 1'b1;
    step(); check("burst_en_e1", en_r, 0);
    step(); check("burst_en_e2", en_r, 1); check("burst_addr_e2", read_addr, 0);
    step(); check("burst_en_e3", en_r, 1); check("burst_addr_e3", read_addr, 1);
    check("burst_valid_e3", pop_valid, 0);
    step(); check("burst_en_e4", en_r, 1); check("burst_addr_e4", read_addr, 2);
    check("burst_valid_e4", pop_valid, 1); check("burst_data_a", pop_data, word(0));
    step(); check("burst_en_e5", en_r, 0); check("burst_data_b", pop_data, word(1));
    step(); check("burst_valid_e6", pop_valid, 1); check("burst_data_c", pop_data, word(2));
    step(); check("burst_valid_end", pop_valid, 0); check("burst_empty", empty, 1);
    check("burst_rd_gray", rd_ptr_gray, 5'b00010); check("burst_fill", fill_level, 0);

    // Asynchronous reset with a word buffered and a read in flight
    wr_ptr_gray = gray(7);
    pop_ready   = 1'b0;
    repeat (4) step();
    check("mid_valid", pop_valid, 1);
    check("mid_data", pop_data, word(3));
    check("mid_fill", fill_level, 4);
    #3;
    reset       = 1'b0;
    wr_ptr_gray = '0;
    #1;
    check("mid_rst_valid", pop_valid, 0);
    check("mid_rst_en", en_r, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_rd_gray", rd_ptr_gray, 0);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_data", pop_data, 0);
    step();
    step();
    reset = 1'b1;
    step();

    // Backpressure: five words, consumer stalled
    wr_ptr_gray = gray(5);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (en_r) begin
        check($sformatf("bp_addr%0d", n), read_addr, n);
        n++;
      end
    end
    check("bp_en_count", n, 2);
    check("bp_en_idle", en_r, 0);
    check("bp_addr_hold", read_addr, 2);
    check("bp_fill", fill_level, 5);
    check("bp_head", pop_data, word(0));
    pop_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), pop_valid, 1);
      check($sformatf("bp_data%0d", k), pop_data, word(k));
      step();
    end
    check("bp_valid_end", pop_valid, 0);
    check("bp_empty_end", empty, 1);

    // Drain up to pointer 15, then cross the address wrap
    wr_ptr_gray = gray(15);
    repeat (20) step();
    check("pre_wrap_empty", empty, 1);
    check("pre_wrap_valid", pop_valid, 0);
    check("pre_wrap_rd_gray", rd_ptr_gray, gray(15));
    wr_ptr_gray = gray(18);
    step(); check("wrap_en_e1", en_r, 0);
    step(); check("wrap_en_e2", en_r, 1); check("wrap_addr15", read_addr, 15);
    step(); check("wrap_addr0", read_addr, 0); check("wrap_gray16", rd_ptr_gray, 5'b11000);
    step(); check("wrap_addr1", read_addr, 1); check("wrap_data15", pop_data, word(15));
    check("wrap_gray17", rd_ptr_gray, gray(17));
    step(); check("wrap_en_e5", en_r, 0); check("wrap_data0", pop_data, word(0));
    check("wrap_gray18", rd_ptr_gray, gray(18));
    step(); check("wrap_data1", pop_data, word(1));
    step(); check("wrap_valid_end", pop_valid, 0); check("wrap_empty", empty, 1);

    // Sustained stream with simultaneous capture and pop, then an empty-edge refill
    wr_ptr_gray = gray(24);
    repeat (3) step();
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("strm_valid%0d", k), pop_valid, 1);
      check($sformatf("strm_data%0d", k), pop_data, word(2 + k));
      check($sformatf("strm_en%0d", k), en_r, (k < 4) ? 1 : 0);
      if (k == 0) check("strm_fill", fill_level, 6);
      if (k == 5) wr_ptr_gray = gray(25);
    end
    step(); check("edge_valid_e1", pop_valid, 0); check("edge_en_e1", en_r, 0);
    step(); check("edge_en_e2", en_r, 1); check("edge_addr", read_addr, 8);
    step(); check("edge_valid_e3", pop_valid, 0);
    step(); check("edge_valid_e4", pop_valid, 1); check("edge_data", pop_data, word(8));
    step(); check("edge_valid_e5", pop_valid, 0); check("edge_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
- Read-side controller of the dual-clock FIFO, running entirely in the clk_r domain.
- Synchronises the Gray-coded write pointer from the write domain and computes the empty condition.
- Drives en_r/read_addr of the simple dual-port RAM and absorbs its 1-cycle read latency.
- Presents first-word-fall-through data to the consumer over a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, width of a FIFO word; matches DATA_W
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits

Ports:
clk_r  input  1  read-domain clock; single clock of this block
reset  input  1  asynchronous, active-low reset
wr_ptr_gray  input  ADDR_WIDTH+1  Gray write pointer, registered in write domain (asynchronous to clk_r)
rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to write domain
en_r  output  1  RAM read enable
read_addr  output  ADDR_WIDTH  RAM read address
ram_out  input  DATA_WIDTH  RAM read data, valid the cycle after en_r
pop_data  output  DATA_WIDTH  head-of-FIFO word
pop_valid  output  1  pop_data holds a valid word
pop_ready  input  1  consumer accepts pop_data this cycle
empty  output  1  no unread words in RAM (rd_ptr_bin == wr_ptr_sync_bin)
fill_level  output  ADDR_WIDTH+1  read-domain word count: RAM words + in-flight read + buffered words

Behaviour:
- Reset (asynchronous, reset=0) clears immediately:
  - sync flops, rd_ptr_bin, rd_ptr_gray, pending flag, and both buffer entries;
  - outputs pop_valid=0, pop_data=0, empty=1, fill_level=0, en_r=0.
- Synchroniser:
  - 2-flop chain on wr_ptr_gray;
  - Gray-to-binary conversion gives wr_ptr_sync_bin;
  - the write-pointer change is visible to empty 2 edges after it changes.
- Output buffer:
  - 2 entries (head + skid), occupancy occ in 0..2;
  - pop_data/pop_valid always reflect the head entry.
- Issue rule:
  - en_r = !empty && (occ + pending - (pop_valid && pop_ready)) < 2;
  - decoded combinationally from registered state and pop_ready.
- Read pointer:
  - read_addr = rd_ptr_bin[ADDR_WIDTH-1:0];
  - on en_r: rd_ptr_bin <= rd_ptr_bin+1, wrapping modulo 2**(ADDR_WIDTH+1);
  - rd_ptr_gray <= bin2gray(rd_ptr_bin+1) in the same edge.
- pending:
  - pending <= en_r;
  - when pending=1, ram_out is captured into the buffer at the next edge: head if it is empty or being popped, otherwise skid.
- Pop:
  - on pop_valid && pop_ready, the skid entry moves to the head;
  - capture and pop in the same cycle are both honoured: no loss, no duplication, order preserved.
- Throughput:
  - 1 word/cycle sustained with pop_ready held high;
  - latency from wr_ptr_gray change to pop_valid = 4 clk_r edges (2 sync, 1 RAM read, 1 capture).
- Backpressure: with pop_ready=0 at most 2 reads are outstanding (occ + pending <= 2); en_r then stays 0 and read_addr is held.
- empty/fill_level:
  - empty is pessimistic: it deasserts only after synchronisation;
  - fill_level = (wr_ptr_sync_bin - rd_ptr_bin) mod 2**(ADDR_WIDTH+1) + pending + occ.
- Wrap: the address wraps from 2**ADDR_WIDTH-1 to 0 while the pointer MSB toggles; empty compares all ADDR_WIDTH+1 bits.
- Reset mid-operation: in-flight RAM data is discarded; the first read after reset is from address 0.

Test Plan:
- Reset check: reset=0 with pop_valid=1 and pending=1 -> pop_valid=0, en_r=0, empty=1, rd_ptr_gray=0, fill_level=0 immediately, without a clock edge.
- Single burst: wr_ptr_gray 0 -> gray(3)=00010, pop_ready=1, RAM[0..2]=A,B,C:
  - en_r at addr 0,1,2 on 3 consecutive cycles starting 2 edges after the change;
  - pop_valid rises 4 edges after the change; A,B,C delivered on consecutive cycles;
  - then empty=1, pop_valid=0, rd_ptr_gray=00010.
- Backpressure: 5 words available, pop_ready=0:
  - exactly 2 en_r pulses (addr 0,1), then en_r=0, read_addr=2, fill_level=5;
  - pop_ready=1 -> words 0..4 delivered in order, 1 per cycle, no gaps after the first.
- Wrap-around (ADDR_WIDTH=4): rd_ptr preloaded by draining to 15, write pointer advanced to binary 18 -> reads addr 15,0,1; rd_ptr_gray passes gray(16)=11000; empty=1 afterwards.
- Simultaneous capture and pop: occ=1, pending=1, pop_ready=1 for 4 cycles with data streaming -> occ stays 1, each word appears exactly once, in order.
- Empty edge: wr_ptr_gray advanced by 1 while the last word is being popped -> the new word follows after 4 edges and pop_valid toggles 1->0->1; no spurious en_r while empty=1.
